// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] opB;
  logic [CW-1:0]    count;
  logic             negQ;
  logic             negR;
  logic             zeroDiv;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic             bZero;
  logic             lastIter;

  logic [2*WIDTH-1:0] mulProd;
  logic [2*WIDTH-1:0] mulSigned;

  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divDiff;
  logic             divGe;
  logic [WIDTH-1:0] divRemNext;
  logic [WIDTH-1:0] divQuoNext;
  logic [WIDTH-1:0] quoFinal;
  logic [WIDTH-1:0] remFinal;

  assign busy  = (state == MUL) || (state == DIV);
  assign ready = (state == DONE);

  // Operands are reduced to magnitudes up front; signs are restored on the final step.
  always_comb begin
    aNeg     = sign & a[WIDTH-1];
    bNeg     = sign & b[WIDTH-1];
    aMag     = aNeg ? -a : a;
    bMag     = bNeg ? -b : b;
    bZero    = (b == '0);
    lastIter = (count == CW'(WIDTH - 1));
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    mulProd = {{WIDTH{1'b0}}, opB} * {{WIDTH{1'b0}}, accLo};
  end
`else
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHiNext;
  logic [WIDTH-1:0] mulLoNext;

  // accHi carries the running partial product, accLo the remaining multiplier bits.
  always_comb begin
    mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    mulHiNext = mulSum[WIDTH:1];
    mulLoNext = {mulSum[0], accLo[WIDTH-1:1]};
    mulProd   = {mulHiNext, mulLoNext};
  end
`endif

  always_comb begin
    mulSigned = negQ ? -mulProd : mulProd;
  end

  // accHi is the partial remainder, accLo shifts dividend bits out and quotient bits in.
  always_comb begin
    divShift   = {accHi, accLo[WIDTH-1]};
    divDiff    = divShift - {1'b0, opB};
    divGe      = (divShift >= {1'b0, opB});
    divRemNext = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
    divQuoNext = {accLo[WIDTH-2:0], divGe};
    quoFinal   = negQ ? -divQuoNext : divQuoNext;
    remFinal   = negR ? -divRemNext : divRemNext;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      accHi       <= '0;
      accLo       <= '0;
      opB         <= '0;
      count       <= '0;
      negQ        <= 1'b0;
      negR        <= 1'b0;
      zeroDiv     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !annul) begin
            opB     <= op ? bMag : aMag;
            accLo   <= op ? aMag : bMag;
            // A zero divisor parks the raw dividend so it can be returned as the remainder.
            accHi   <= (op && bZero) ? a : '0;
            zeroDiv <= op && bZero;
            negQ    <= aNeg ^ bNeg;
            negR    <= aNeg;
            count   <= '0;
            state   <= op ? DIV : MUL;
          end
        end

        MUL: begin
          if (annul) begin
            count <= '0;
            state <= IDLE;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            {hi, lo}    <= mulSigned;
            div_by_zero <= 1'b0;
            state       <= DONE;
`else
            accHi <= mulHiNext;
            accLo <= mulLoNext;
            count <= count + CW'(1);
            if (lastIter) begin
              {hi, lo}    <= mulSigned;
              div_by_zero <= 1'b0;
              count       <= '0;
              state       <= DONE;
            end
`endif
          end
        end

        DIV: begin
          if (annul) begin
            count <= '0;
            state <= IDLE;
          end else if (zeroDiv) begin
            hi          <= accHi;
            lo          <= '1;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            accHi <= divRemNext;
            accLo <= divQuoNext;
            count <= count + CW'(1);
            if (lastIter) begin
              hi          <= remFinal;
              lo          <= quoFinal;
              div_by_zero <= 1'b0;
              count       <= '0;
              state       <= DONE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases from the requirements plus
// randomized operations scored against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic         sign;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         annul;
  logic         busy;
  logic         ready;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         divByZero;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] expHi  = '0;
  logic [W-1:0] expLo  = '0;
  logic         expDbz = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .sign       (sign),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .busy       (busy),
    .ready      (ready),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(divByZero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference results straight from integer arithmetic on the operand values.
  function automatic void refModel(input logic o, input logic s, input logic [W-1:0] x,
                                   input logic [W-1:0] y, output logic [W-1:0] rh,
                                   output logic [W-1:0] rl, output logic rz);
    longint      sx;
    longint      sy;
    longint      p;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rz = 1'b0;
    if (!o) begin
      if (s) begin
        p = sx * sy;
        {rh, rl} = p;
      end else begin
        up = {32'b0, x} * {32'b0, y};
        {rh, rl} = up;
      end
    end else if (y == '0) begin
      rl = '1;
      rh = x;
      rz = 1'b1;
    end else if (s) begin
      rl = 32'(sx / sy);
      rh = 32'(sx % sy);
    end else begin
      rl = x / y;
      rh = x % y;
    end
  endfunction

  task automatic applyStimulus(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    sign  = s;
    a     = x;
    b     = y;
    annul = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic runOp(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string tag);
    int cyc;
    int expLat;
    refModel(o, s, x, y, expHi, expLo, expDbz);
    expLat = o ? ((y == '0) ? 2 : W + 1) : MUL_LAT;
    applyStimulus(o, s, x, y);
    checkOutput({tag, " busy"}, 64'(busy), 64'(1));
    cyc = 1;
    while (!ready && cyc < 200) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 1'($urandom);
      sign  = 1'($urandom);
      a     = $urandom;
      b     = $urandom;
      tick();
      cyc++;
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, 64'(cyc), 64'(expLat));
    checkOutput({tag, " busyAtReady"}, 64'(busy), 64'(0));
    checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
    if (o) checkOutput({tag, " divByZero"}, 64'(divByZero), 64'(expDbz));
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, " idleAfterDone"}, {62'b0, busy, ready}, 64'(0));
  endtask

  initial begin
    int readySeen;
    rst   = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    annul = 1'b0;
    tick();
    tick();
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset ready", 64'(ready), 64'(0));
    checkOutput("reset hilo", {hi, lo}, 64'(0));
    checkOutput("reset dbz", 64'(divByZero), 64'(0));
    rst = 1'b1;
    tick();

    runOp(1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, "umulMax");
    runOp(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, "sdivNeg7");
    runOp(1'b1, 1'b0, 32'h12345678, 32'd0, "divZero");
    runOp(1'b1, 1'b0, 32'd10, 32'd3, "udiv10by3");
    runOp(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, "sdivMinByNeg1");
    runOp(1'b0, 1'b1, 32'h80000000, 32'h80000000, "smulMinMin");
    runOp(1'b0, 1'b1, 32'hFFFFFFFF, 32'd7, "smulNeg1");
    runOp(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, "sdivPosByNeg");

    // Abort a divide partway through; outputs must keep the prior zero-divide result.
    runOp(1'b1, 1'b0, 32'hCAFEF00D, 32'd0, "divZeroPrior");
    applyStimulus(1'b1, 1'b0, 32'h0BADBEEF, 32'd17);
    repeat (9) begin
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    annul = 1'b1;
    tick();
    annul = 1'b0;
    checkOutput("annul busy", 64'(busy), 64'(0));
    readySeen = 0;
    repeat (40) begin
      tick();
      if (ready) readySeen++;
    end
    checkOutput("annul noReady", 64'(readySeen), 64'(0));
    checkOutput("annul hiHold", 64'(hi), 64'(expHi));
    checkOutput("annul loHold", 64'(lo), 64'(expLo));
    checkOutput("annul dbzHold", 64'(divByZero), 64'(expDbz));

    op    = 1'b0;
    start = 1'b1;
    annul = 1'b1;
    tick();
    start = 1'b0;
    annul = 1'b0;
    checkOutput("annulWins busy", 64'(busy), 64'(0));
    tick();
    checkOutput("annulWins ready", 64'(ready), 64'(0));

    // Reset in the middle of a multiply, with start held during reset.
    applyStimulus(1'b0, 1'b0, 32'h13579BDF, 32'h2468ACE0);
    repeat (14) tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    checkOutput("midReset busyReady", {62'b0, busy, ready}, 64'(0));
    checkOutput("midReset hilo", {hi, lo}, 64'(0));
    checkOutput("midReset dbz", 64'(divByZero), 64'(0));
    rst   = 1'b1;
    start = 1'b0;
    tick();
    checkOutput("resetStart ignored", 64'(busy), 64'(0));
    runOp(1'b0, 1'b0, 32'h13579BDF, 32'h2468ACE0, "afterReset");

    for (int i = 0; i < 16; i++) begin
      logic         ro;
      logic         rs;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 1'($urandom);
      rs = 1'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      runOp(ro, rs, ra, rb, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal: even, 8..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  1  0 = multiply, 1 = divide.
REQ-006 SHALL have port sign  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port a  input  WIDTH  multiplicand / dividend.
REQ-008 SHALL have port b  input  WIDTH  multiplier / divisor.
REQ-009 SHALL have port annul  input  1  abort the operation in progress.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port hi  output  WIDTH  product high half / remainder.
REQ-013 SHALL have port lo  output  WIDTH  product low half / quotient.
REQ-014 SHALL have port div_by_zero  output  1  last completed divide had b = 0.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-016 In IDLE, start=1 and annul=0 at edge E SHALL latch a, b, op, sign and enter MUL or DIV, and busy SHALL be high from cycle E+1.
REQ-017 MUL SHALL use iterative shift-add on operand magnitudes, one bit per cycle, for WIDTH cycles, then enter DONE.
REQ-018 DIV SHALL use restoring division on magnitudes, one quotient bit per cycle, for WIDTH cycles, then enter DONE.
REQ-019 Iterative latency: ready high exactly in cycle E+WIDTH+1, with busy low in that cycle; the next edge returns to IDLE.
REQ-020 Signed multiply: product negated when sign(a) XOR sign(b); {hi,lo} is the exact 2*WIDTH-bit result.
REQ-021 Signed divide: quotient negative when sign(a) XOR sign(b); remainder takes sign of a; MIN / -1 gives lo = MIN and hi = 0.
REQ-022 Divide with b = 0: DIV lasts 1 cycle (ready at E+2), lo = all ones, hi = a, div_by_zero = 1.
REQ-023 div_by_zero SHALL update only on ready and clear on any non-zero-divisor completion.
REQ-024 hi and lo SHALL update only in the DONE cycle and hold until the next completion.
REQ-025 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-026 annul=1 in MUL or DIV SHALL return the FSM to IDLE at the next edge, with no ready pulse and hi/lo/div_by_zero unchanged.
REQ-027 annul in DONE SHALL be ignored, so the completion stands.
REQ-028 start and annul both high in IDLE: annul wins and no operation starts.
REQ-029 A new start is accepted in the first IDLE cycle after DONE (back-to-back spacing WIDTH+2 cycles).

Reset
REQ-030 rst=0 at an edge SHALL force IDLE, busy=0, ready=0, hi=0, lo=0, div_by_zero=0 and the iteration counter to 0, including mid-operation.
REQ-031 start SHALL be ignored in any cycle where rst=0.

Configuration
REQ-032 With macro MULDIV_FAST_MUL_EN defined, multiply SHALL be a single-cycle combinational product registered into DONE (ready at E+2), and the MUL iteration logic SHALL be removed.
REQ-033 Without MULDIV_FAST_MUL_EN, multiply SHALL be iterative per REQ-017/019; divide behaviour SHALL be identical either way.

Verification (WIDTH=32)
REQ-034 Unsigned mul, a=0xFFFFFFFF, b=2, start at edge 0 -> ready in cycle 33, hi=0x00000001, lo=0xFFFFFFFE; with MULDIV_FAST_MUL_EN ready in cycle 2, same values.
REQ-035 Signed div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0, ready in cycle 33.
REQ-036 Divide, a=0x12345678, b=0 -> ready in cycle 2, lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1; then a=10, b=3 unsigned -> lo=3, hi=1, div_by_zero=0.
REQ-037 Signed div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 Start div, annul in cycle 10 -> busy low from cycle 11, no ready, hi/lo hold prior values; start pulses during busy are ignored.
REQ-039 rst=0 in cycle 15 of a multiply -> all outputs 0 next cycle; a fresh start then completes normally.
